// File: rtl/tea_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tea_pkg
//  Brief   : Shared constants, state encoding and round function for tea.
//  Rev     : 1.0  initial release
// ============================================================================
package tea_pkg;

    localparam logic [31:0]       DELTA        = 32'h9E37_79B9;
    localparam logic [31:0]       SUM_DEC_INIT = 32'hC6EF_3720;
    localparam int                ROUNDS       = 32;

    localparam logic [3:0][31:0]  KEY          = '0;
    localparam logic [31:0]       PT0          = 32'h0000_0000;
    localparam logic [31:0]       PT1          = 32'h0000_0000;
    localparam logic [31:0]       CT0          = 32'h41EA_3A0A;
    localparam logic [31:0]       CT1          = 32'h94BA_A940;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    function automatic logic [31:0] tea_f(
        input logic [31:0] x,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tea_engine.sv
`default_nettype none
// ============================================================================
//  Module  : tea_engine
//  Brief   : Iterative TEA engine, one full cycle per clock, 32 cycles total.
//  Rev     : 1.0  initial release
// ============================================================================
module tea_engine
    import tea_pkg::*;
#(
    parameter bit DECRYPT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] v0,
    output logic [31:0] v1,
    output logic        done
);

    localparam logic [31:0] V0_INIT  = DECRYPT ? CT0 : PT0;
    localparam logic [31:0] V1_INIT  = DECRYPT ? CT1 : PT1;
    localparam logic [31:0] SUM_INIT = DECRYPT ? SUM_DEC_INIT : 32'h0;
    localparam logic [5:0]  LAST     = 6'(ROUNDS);

    eng_state_t  state_q, state_d;
    logic [31:0] v0_q, v0_d;
    logic [31:0] v1_q, v1_d;
    logic [31:0] sum_q, sum_d;
    logic [5:0]  count_q, count_d;

    logic [31:0] v0_nxt, v1_nxt, sum_nxt;

    if (DECRYPT) begin : g_dec
        logic [31:0] v1_t;
        assign v1_t    = v1_q - tea_f(v0_q, sum_q, KEY[2], KEY[3]);
        assign v1_nxt  = v1_t;
        assign v0_nxt  = v0_q - tea_f(v1_t, sum_q, KEY[0], KEY[1]);
        assign sum_nxt = sum_q - DELTA;
    end else begin : g_enc
        // Encrypt uses the already-advanced sum within the same cycle.
        logic [31:0] s_t;
        logic [31:0] v0_t;
        assign s_t     = sum_q + DELTA;
        assign v0_t    = v0_q + tea_f(v1_q, s_t, KEY[0], KEY[1]);
        assign v0_nxt  = v0_t;
        assign v1_nxt  = v1_q + tea_f(v0_t, s_t, KEY[2], KEY[3]);
        assign sum_nxt = s_t;
    end

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (run) begin
                    v0_d    = v0_nxt;
                    v1_d    = v1_nxt;
                    sum_d   = sum_nxt;
                    count_d = count_q + 6'd1;
                    state_d = (count_d == LAST) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            v0_q    <= V0_INIT;
            v1_q    <= V1_INIT;
            sum_q   <= SUM_INIT;
            count_q <= 6'd0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign v0   = v0_q;
    assign v1   = v1_q;
    assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/tea.sv
`default_nettype none
// ============================================================================
//  Module  : tea
//  Brief   : Self-checking TEA demo: encrypt and decrypt engines with match flags.
//  Rev     : 1.0  initial release
// ============================================================================
module tea
    import tea_pkg::*;
(
    input  logic clk,
    input  logic reset_enc,
    input  logic reset_dec,
    input  logic run_enc,
    input  logic run_dec,
    output logic done_enc,
    output logic done_dec,
    output logic v0_out_enc,
    output logic v1_out_enc,
    output logic v0_out_dec,
    output logic v1_out_dec
);

    logic [31:0] enc_v0, enc_v1;
    logic [31:0] dec_v0, dec_v1;

    tea_engine #(.DECRYPT(1'b0)) u_enc (
        .clk  (clk),
        .rst  (reset_enc),
        .run  (run_enc),
        .v0   (enc_v0),
        .v1   (enc_v1),
        .done (done_enc)
    );

    tea_engine #(.DECRYPT(1'b1)) u_dec (
        .clk  (clk),
        .rst  (reset_dec),
        .run  (run_dec),
        .v0   (dec_v0),
        .v1   (dec_v1),
        .done (done_dec)
    );

    assign v0_out_enc = done_enc && (enc_v0 == CT0);
    assign v1_out_enc = done_enc && (enc_v1 == CT1);
    assign v0_out_dec = done_dec && (dec_v0 == PT0);
    assign v1_out_dec = done_dec && (dec_v1 == PT1);

endmodule
`default_nettype wire

// File: tb/tb_tea.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tea
//  Brief   : Scoreboard bench for tea: expected completions queued at start.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_tea;

    logic clk = 1'b0;
    logic reset_enc, reset_dec, run_enc, run_dec;
    logic done_enc, done_dec, v0_out_enc, v1_out_enc, v0_out_dec, v1_out_dec;

    always #5 clk = ~clk;

    tea dut (
        .clk        (clk),
        .reset_enc  (reset_enc),
        .reset_dec  (reset_dec),
        .run_enc    (run_enc),
        .run_dec    (run_dec),
        .done_enc   (done_enc),
        .done_dec   (done_dec),
        .v0_out_enc (v0_out_enc),
        .v1_out_enc (v1_out_enc),
        .v0_out_dec (v0_out_dec),
        .v1_out_dec (v1_out_dec)
    );

    typedef struct {
        int          cyc;
        logic [31:0] v0;
        logic [31:0] v1;
    } exp_t;

    exp_t q_enc[$];
    exp_t q_dec[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_enc_prev = 1'b0;
    logic done_dec_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Reference TEA with zero key; dec=1 runs the inverse starting from DELTA*32.
    function automatic logic [63:0] tea_model(input bit dec, input int n,
                                              input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, s;
        a = a_in;
        b = b_in;
        s = dec ? 32'hC6EF3720 : 32'h0;
        for (int i = 0; i < n; i++) begin
            if (!dec) begin
                s = s + 32'h9E3779B9;
                a = a + (((b << 4) + 32'h0) ^ (b + s) ^ ((b >> 5) + 32'h0));
                b = b + (((a << 4) + 32'h0) ^ (a + s) ^ ((a >> 5) + 32'h0));
            end else begin
                b = b - (((a << 4) + 32'h0) ^ (a + s) ^ ((a >> 5) + 32'h0));
                a = a - (((b << 4) + 32'h0) ^ (b + s) ^ ((b >> 5) + 32'h0));
                s = s - 32'h9E3779B9;
            end
        end
        return {a, b};
    endfunction

    logic [63:0] enc_full, dec_full;

    always @(negedge clk) begin
        exp_t e;
        if (done_enc && !done_enc_prev) begin
            if (q_enc.size() == 0) begin
                check("enc_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q_enc.pop_front();
                check("enc_latency", 64'(cyc), 64'(e.cyc));
                check("enc_v_internal", {dut.u_enc.v0_q, dut.u_enc.v1_q}, {e.v0, e.v1});
                check("enc_flags", {62'd0, v0_out_enc, v1_out_enc}, 64'd3);
            end
        end
        if (done_dec && !done_dec_prev) begin
            if (q_dec.size() == 0) begin
                check("dec_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q_dec.pop_front();
                check("dec_latency", 64'(cyc), 64'(e.cyc));
                check("dec_v_internal", {dut.u_dec.v0_q, dut.u_dec.v1_q}, {e.v0, e.v1});
                check("dec_sum_internal", 64'(dut.u_dec.sum_q), 64'd0);
                check("dec_flags", {62'd0, v0_out_dec, v1_out_dec}, 64'd3);
            end
        end
        done_enc_prev = done_enc;
        done_dec_prev = done_dec;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_enc(input int lat);
        exp_t e;
        e.cyc = cyc + lat;
        e.v0  = enc_full[63:32];
        e.v1  = enc_full[31:0];
        q_enc.push_back(e);
    endtask

    task automatic push_dec(input int lat);
        exp_t e;
        e.cyc = cyc + lat;
        e.v0  = dec_full[63:32];
        e.v1  = dec_full[31:0];
        q_dec.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q_enc.size() != 0 || q_dec.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        if (q_enc.size() != 0 || q_dec.size() != 0) begin
            check("done_timeout", 64'(q_enc.size() + q_dec.size()), 64'd0);
            q_enc.delete();
            q_dec.delete();
        end
    endtask

    logic [63:0] mid;

    initial begin
        enc_full  = tea_model(1'b0, 32, 32'h0, 32'h0);
        dec_full  = tea_model(1'b1, 32, 32'h41EA3A0A, 32'h94BAA940);
        reset_enc = 1'b1;
        reset_dec = 1'b1;
        run_enc   = 1'b0;
        run_dec   = 1'b0;
        step(2);
        check("reset_outputs",
              {58'd0, done_enc, done_dec, v0_out_enc, v1_out_enc, v0_out_dec, v1_out_dec}, 64'd0);
        check("reset_enc_v", {dut.u_enc.v0_q, dut.u_enc.v1_q}, 64'h0);
        check("reset_dec_v", {dut.u_dec.v0_q, dut.u_dec.v1_q}, 64'h41EA3A0A_94BAA940);

        // Straight encrypt run, then hold after done, then reset clears outputs.
        reset_enc = 1'b0;
        run_enc   = 1'b1;
        push_enc(32);
        step(31);
        check("enc_not_done_at_31", {63'd0, done_enc}, 64'd0);
        wait_drain(10);
        step(20);
        check("enc_hold_flags", {61'd0, done_enc, v0_out_enc, v1_out_enc}, 64'd7);
        check("enc_hold_v", {dut.u_enc.v0_q, dut.u_enc.v1_q}, enc_full);
        reset_enc = 1'b1;
        step(1);
        check("enc_reset_after_done", {61'd0, done_enc, v0_out_enc, v1_out_enc}, 64'd0);

        // Straight decrypt run.
        reset_dec = 1'b0;
        run_dec   = 1'b1;
        push_dec(32);
        wait_drain(40);
        reset_dec = 1'b1;
        run_dec   = 1'b0;
        step(1);
        check("dec_reset_after_done", {61'd0, done_dec, v0_out_dec, v1_out_dec}, 64'd0);

        // Pause for 10 cycles after 15 rounds.
        reset_enc = 1'b0;
        run_enc   = 1'b1;
        push_enc(42);
        step(15);
        run_enc = 1'b0;
        mid = tea_model(1'b0, 15, 32'h0, 32'h0);
        step(1);
        check("pause_v_start", {dut.u_enc.v0_q, dut.u_enc.v1_q}, mid);
        step(9);
        check("pause_v_end", {dut.u_enc.v0_q, dut.u_enc.v1_q}, mid);
        check("pause_count", 64'(dut.u_enc.count_q), 64'd15);
        run_enc = 1'b1;
        wait_drain(40);

        // Reset at count 20 with run held high, then a full fresh run.
        reset_enc = 1'b1;
        step(1);
        reset_enc = 1'b0;
        step(20);
        check("mid_count", 64'(dut.u_enc.count_q), 64'd20);
        reset_enc = 1'b1;
        step(1);
        check("mid_reset_v", {dut.u_enc.v0_q, dut.u_enc.v1_q}, 64'h0);
        check("mid_reset_count", 64'(dut.u_enc.count_q), 64'd0);
        reset_enc = 1'b0;
        push_enc(32);
        wait_drain(40);

        // Both engines concurrently; reset with run high performs no round.
        reset_enc = 1'b1;
        reset_dec = 1'b1;
        run_dec   = 1'b1;
        step(2);
        check("both_reset_enc_v", {dut.u_enc.v0_q, dut.u_enc.v1_q}, 64'h0);
        check("both_reset_dec_v", {dut.u_dec.v0_q, dut.u_dec.v1_q}, 64'h41EA3A0A_94BAA940);
        reset_enc = 1'b0;
        reset_dec = 1'b0;
        push_enc(32);
        push_dec(32);
        step(5);
        reset_dec = 1'b1;
        step(1);
        check("dec_rerun_reset_v", {dut.u_dec.v0_q, dut.u_dec.v1_q}, 64'h41EA3A0A_94BAA940);
        void'(q_dec.pop_back());
        reset_dec = 1'b0;
        push_dec(32);
        wait_drain(60);
        check("both_done", {62'd0, done_enc, done_dec}, 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
